// File: rtl/jump_traj_gen.sv
// Ballistic jump trajectory generator: one integration step per clk_jump tick,
// with start handshake, platform landing, miss detection and output saturation.
module jump_traj_gen #(
  parameter int unsigned H_W     = 9,
  parameter int unsigned D_W     = 11,
  parameter int unsigned V_W     = 11,
  parameter int unsigned GRAVITY = 1,
  parameter int unsigned VX      = 1,
  parameter int unsigned FRAC    = 0
) (
  input  logic           clk_jump,
  input  logic           rst_n,
  input  logic           en,
  input  logic           i_start,
  input  logic [V_W-1:0] i_v_init,
  input  logic [H_W-1:0] i_land_h,
  output logic [H_W-1:0] o_height,
  output logic [D_W-1:0] o_dist,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_miss
);

  localparam int unsigned ACC_W = 2 * V_W + FRAC + 2;

  localparam logic signed [ACC_W-1:0] ZERO   = '0;
  localparam logic signed [ACC_W-1:0] GRAV_S = ACC_W'(GRAVITY);
  localparam logic signed [ACC_W-1:0] HMAX_S = ACC_W'((64'd1 << H_W) - 64'd1);
  localparam logic        [D_W:0]     DMAX   = {1'b0, {D_W{1'b1}}};
  localparam logic        [D_W:0]     VX_E   = (D_W + 1)'(VX);

  typedef enum logic [1:0] {StIdle, StRise, StFall, StDone} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] vel_q, vel_d;
  logic signed [ACC_W-1:0] peak_q, peak_d;
  logic        [H_W-1:0]   land_h_q, land_h_d;
  logic        [H_W-1:0]   height_q, height_d;
  logic        [D_W-1:0]   dist_q, dist_d;
  logic                    miss_q, miss_d;

  logic signed [ACC_W-1:0] acc_n;
  logic signed [ACC_W-1:0] vel_n;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [ACC_W-1:0] land_ext;
  logic signed [ACC_W-1:0] vel_init;
  logic        [D_W:0]     dist_sum;
  logic        [D_W-1:0]   dist_next;
  logic        [H_W-1:0]   height_sat;

  always_comb begin
    acc_n    = acc_q + vel_q;
    vel_n    = vel_q - GRAV_S;
    acc_sh   = acc_n >>> FRAC;
    land_ext = $signed({{(ACC_W - H_W){1'b0}}, land_h_q});
    vel_init = $signed({{(ACC_W - V_W){1'b0}}, i_v_init}) <<< FRAC;

    dist_sum  = {1'b0, dist_q} + VX_E;
    dist_next = (dist_sum > DMAX) ? {D_W{1'b1}} : dist_sum[D_W-1:0];

    if (acc_sh < ZERO) begin
      height_sat = '0;
    end else if (acc_sh > HMAX_S) begin
      height_sat = '1;
    end else begin
      height_sat = acc_sh[H_W-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    vel_d    = vel_q;
    peak_d   = peak_q;
    land_h_d = land_h_q;
    height_d = height_q;
    dist_d   = dist_q;
    miss_d   = miss_q;

    if (!en) begin
      state_d  = StIdle;
      acc_d    = '0;
      vel_d    = '0;
      peak_d   = '0;
      land_h_d = '0;
      height_d = '0;
      dist_d   = '0;
      miss_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (i_start) begin
            land_h_d = i_land_h;
            acc_d    = '0;
            vel_d    = vel_init;
            peak_d   = '0;
            height_d = '0;
            dist_d   = '0;
            miss_d   = 1'b0;
            state_d  = (i_v_init != '0) ? StRise : StFall;
          end
        end
        StRise: begin
          acc_d    = acc_n;
          vel_d    = vel_n;
          dist_d   = dist_next;
          height_d = height_sat;
          if (acc_sh > peak_q) begin
            peak_d = acc_sh;
          end
          if (vel_n <= ZERO) begin
            state_d = StFall;
          end
        end
        StFall: begin
          acc_d    = acc_n;
          vel_d    = vel_n;
          dist_d   = dist_next;
          height_d = height_sat;
          // Platform only counts on the way down; the floor always ends the jump,
          // which also covers a zero-velocity launch.
          if ((vel_q < ZERO) && (land_ext <= peak_q) && (acc_sh <= land_ext)) begin
            height_d = land_h_q;
            miss_d   = 1'b0;
            state_d  = StDone;
          end else if (acc_n <= ZERO) begin
            height_d = '0;
            miss_d   = (land_ext > peak_q);
            state_d  = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_jump) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      vel_q    <= '0;
      peak_q   <= '0;
      land_h_q <= '0;
      height_q <= '0;
      dist_q   <= '0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      vel_q    <= vel_d;
      peak_q   <= peak_d;
      land_h_q <= land_h_d;
      height_q <= height_d;
      dist_q   <= dist_d;
      miss_q   <= miss_d;
    end
  end

  assign o_height = height_q;
  assign o_dist   = dist_q;
  assign o_miss   = miss_q;
  assign o_busy   = (state_q == StRise) || (state_q == StFall);
  assign o_done   = (state_q == StDone);

endmodule

// File: tb/tb_jump_traj_gen.sv
// Bench for jump_traj_gen: closed-form ballistic model with landing rules,
// directed scenarios plus randomized launches.
module tb_jump_traj_gen;

  logic        clk_jump;
  logic        rst_n;
  logic        en;
  logic        i_start;
  logic [10:0] i_v_init;
  logic [8:0]  i_land_h;
  logic [8:0]  o_height;
  logic [10:0] o_dist;
  logic        o_busy;
  logic        o_done;
  logic        o_miss;

  int n_vec = 0;
  int n_err = 0;
  int heights[$];
  int t1_exp[11] = '{5, 9, 12, 14, 15, 15, 14, 12, 9, 5, 0};

  jump_traj_gen dut (
    .clk_jump(clk_jump),
    .rst_n   (rst_n),
    .en      (en),
    .i_start (i_start),
    .i_v_init(i_v_init),
    .i_land_h(i_land_h),
    .o_height(o_height),
    .o_dist  (o_dist),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_miss  (o_miss)
  );

  initial begin
    clk_jump = 1'b0;
    forever #5 clk_jump = ~clk_jump;
  end

  // Height k ticks after launch with unit gravity: sum of v0, v0-1, ..., v0-k+1.
  function automatic longint traj_h(input int v0, input int k);
    return longint'(k) * v0 - (longint'(k) * (k - 1)) / 2;
  endfunction

  function automatic int sat_h(input longint h);
    if (h < 0) return 0;
    if (h > 511) return 511;
    return int'(h);
  endfunction

  task automatic do_start(input int v0, input int lh);
    i_start  = 1'b1;
    i_v_init = 11'(v0);
    i_land_h = 9'(lh);
    @(posedge clk_jump);
    #1;
    i_start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    n_vec++;
    if ({o_height, o_dist, o_busy, o_done, o_miss} !== 23'd0) begin
      n_err++;
      $display("FAIL %s: h=%0d d=%0d busy=%b done=%b miss=%b, required all 0",
               tag, o_height, o_dist, o_busy, o_done, o_miss);
    end
  endtask

  // Launch and follow one jump tick by tick; optional stray start at pulse_tick.
  task automatic run_traj(input int v0, input int lh, input int pulse_tick);
    longint peak;
    longint h;
    int     land_k;
    int     land_val;
    bit     exp_miss;
    int     exp_h;
    int     exp_d;
    peak     = (longint'(v0) * (v0 + 1)) / 2;
    land_k   = 0;
    land_val = 0;
    exp_miss = 1'b0;
    for (int k = v0 + 1; k < 6000 && land_k == 0; k++) begin
      h = traj_h(v0, k);
      if (lh <= peak && k > v0 + 1 && h <= lh) begin
        land_k   = k;
        land_val = lh;
        exp_miss = 1'b0;
      end else if (h <= 0) begin
        land_k   = k;
        land_val = 0;
        exp_miss = (lh > peak);
      end
    end

    do_start(v0, lh);
    n_vec++;
    if (o_height !== 9'd0 || o_dist !== 11'd0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
      n_err++;
      $display("FAIL start v0=%0d: h=%0d d=%0d busy=%b done=%b, required 0 0 1 0",
               v0, o_height, o_dist, o_busy, o_done);
    end

    heights.delete();
    for (int k = 1; k <= land_k; k++) begin
      @(posedge clk_jump);
      #1;
      if (k == pulse_tick + 1) i_start = 1'b0;
      exp_h = (k == land_k) ? land_val : sat_h(traj_h(v0, k));
      exp_d = (k > 2047) ? 2047 : k;
      heights.push_back(int'(o_height));
      n_vec++;
      if (o_height !== 9'(exp_h)) begin
        n_err++;
        $display("FAIL height v0=%0d lh=%0d tick %0d: got %0d, required %0d",
                 v0, lh, k, o_height, exp_h);
      end
      n_vec++;
      if (o_dist !== 11'(exp_d)) begin
        n_err++;
        $display("FAIL dist v0=%0d tick %0d: got %0d, required %0d", v0, k, o_dist, exp_d);
      end
      n_vec++;
      if (o_done !== (k == land_k) || o_busy !== (k != land_k)) begin
        n_err++;
        $display("FAIL status v0=%0d tick %0d: done=%b busy=%b, required done=%b",
                 v0, k, o_done, o_busy, k == land_k);
      end
      if (k == pulse_tick) begin
        i_start  = 1'b1;
        i_v_init = 11'd9;
        i_land_h = 9'd3;
      end
    end
    n_vec++;
    if (o_miss !== exp_miss) begin
      n_err++;
      $display("FAIL miss v0=%0d lh=%0d: got %b, required %b", v0, lh, o_miss, exp_miss);
    end
  endtask

  task automatic check_t1_list(input string tag);
    n_vec++;
    if (heights.size() != 11) begin
      n_err++;
      $display("FAIL %s length: got %0d ticks, required 11", tag, heights.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_vec++;
        if (heights[i] != t1_exp[i]) begin
          n_err++;
          $display("FAIL %s tick %0d: got %0d, required %0d", tag, i + 1, heights[i], t1_exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    i_start = 1'b0;
    i_v_init = '0;
    i_land_h = '0;
    repeat (3) @(posedge clk_jump);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk_jump);
    #1;
    check_idle("idle_after_reset");
  endtask

  task automatic test_basic();
    run_traj(5, 0, 0);
    check_t1_list("t1");
    run_traj(5, 10, 0);
    run_traj(5, 20, 0);
    run_traj(5, 15, 0);
  endtask

  task automatic test_extremes();
    int mx;
    run_traj(0, 0, 0);
    run_traj(0, 7, 0);
    run_traj(2047, 0, 0);
    mx = 0;
    foreach (heights[i]) if (heights[i] > mx) mx = heights[i];
    n_vec++;
    if (mx != 511) begin
      n_err++;
      $display("FAIL sat_max: got %0d, required 511", mx);
    end
  endtask

  task automatic test_abort();
    do_start(5, 0);
    repeat (6) @(posedge clk_jump);
    #1;
    rst_n = 1'b0;
    @(posedge clk_jump);
    #1;
    check_idle("abort_rst");
    rst_n = 1'b1;
    run_traj(5, 0, 0);
    check_t1_list("t1_after_rst");
    do_start(5, 0);
    repeat (6) @(posedge clk_jump);
    #1;
    en = 1'b0;
    @(posedge clk_jump);
    #1;
    check_idle("abort_en");
    en = 1'b1;
    run_traj(5, 0, 0);
    check_t1_list("t1_after_en");
  endtask

  task automatic test_ignore_start();
    run_traj(5, 0, 3);
    check_t1_list("t1_stray_start");
  endtask

  task automatic test_done_hold_restart();
    run_traj(4, 6, 0);
    repeat (3) begin
      @(posedge clk_jump);
      #1;
      n_vec++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_height !== 9'd6 || o_dist !== 11'd8
          || o_miss !== 1'b0) begin
        n_err++;
        $display("FAIL done_hold: done=%b busy=%b h=%0d d=%0d miss=%b, required 1 0 6 8 0",
                 o_done, o_busy, o_height, o_dist, o_miss);
      end
    end
    run_traj(3, 2, 0);
  endtask

  task automatic test_random();
    int v0;
    int pk;
    int lh;
    for (int n = 0; n < 25; n++) begin
      v0 = int'($urandom_range(0, 80));
      pk = v0 * (v0 + 1) / 2;
      lh = int'($urandom_range(0, (pk + 20 > 511) ? 511 : pk + 20));
      run_traj(v0, lh, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_abort();
    test_ignore_start();
    test_done_hold_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
